// File: rtl/vlsu_pipe.sv
// vlsu_pipe: pipelined vector load/store unit driving an AHB-Lite master port.
// Define VLSU_INDEXED_EN to make mop 01/11 use indexed addressing from vs2_rdata_i.
//
// state   | meaning
// S_IDLE  | waiting for a load/store request
// S_RUN   | one element per accepted address phase, data phase of the previous one overlapped
// S_DRAIN | last element issued, waiting for its data phase
// S_DONE  | completion pulse; final load row writeback lands in this cycle
module vlsu_pipe #(
    parameter int  LANES  = 4,
    parameter int  ELEMS  = 4,
    localparam int ELEM_B = $clog2(ELEMS),
    localparam int N      = LANES*ELEMS
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              req_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       rs1_i,
    input  logic [31:0]       rs2_i,
    input  logic [31:0]       vs2_rdata_i [LANES],
    input  logic [31:0]       vs3_rdata_i [LANES],
    input  logic [N-1:0]      mask_i,
    output logic [ELEM_B-1:0] vrf_rd_elem_o,
    output logic [ELEM_B-1:0] vrf_wr_elem_o,
    output logic              vrf_wr_en_o [LANES],
    output logic [31:0]       vrf_wdata_o [LANES],
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [31:0]       hwdata_o,
    input  logic [31:0]       hrdata_i,
    input  logic              hready_i,
    input  logic              hresp_i
);
    localparam int         LANE_B   = $clog2(LANES);
    localparam int         IDX_W    = $clog2(N);
    localparam logic [6:0] OP_LOAD  = 7'b0000111;
    localparam logic [6:0] OP_STORE = 7'b0100111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic              store_q, vm_q, indexed_q, err_q, dp_vld_q, dp_act_q;
    logic [N-1:0]      mask_q;
    logic [31:0]       base_q, acc_q, step_q, wdata_q;
    logic [IDX_W-1:0]  idx_q, dp_idx_q;
    logic [ELEM_B-1:0] wr_row_q;
    logic [LANES-1:0]  wr_en_q, wb_en;
    logic [31:0]       rowbuf_q [LANES];

    logic [LANE_B-1:0] lane_a, dp_lane;
    logic [ELEM_B-1:0] row_a, dp_row;
    logic              elem_act, err_now, dp_done, op_ok;
    logic [31:0]       idx_off, addr_a;

    assign lane_a   = idx_q[LANE_B-1:0];
    assign row_a    = idx_q[IDX_W-1:LANE_B];
    assign dp_lane  = dp_idx_q[LANE_B-1:0];
    assign dp_row   = dp_idx_q[IDX_W-1:LANE_B];
    assign elem_act = vm_q | mask_q[idx_q];
    assign op_ok    = (instr_i[6:0] == OP_LOAD) || (instr_i[6:0] == OP_STORE);

`ifdef VLSU_INDEXED_EN
    assign idx_off = vs2_rdata_i[lane_a];
`else
    assign idx_off = 32'h0;
`endif
    // Unit and strided share a running accumulator; indexed adds the lane offset to the base.
    assign addr_a  = indexed_q ? base_q + idx_off : acc_q;
    assign err_now = dp_vld_q & dp_act_q & hresp_i;
    assign dp_done = dp_vld_q & hready_i & ~err_now;

    always_comb begin
        wb_en = '0;
        for (int l = 0; l < LANES; l++) wb_en[l] = vm_q | mask_q[{dp_row, LANE_B'(l)}];
    end

    assign htrans_o      = (state_q == S_RUN && elem_act && !err_now) ? 2'b10 : 2'b00;
    assign haddr_o       = (state_q == S_RUN) ? addr_a : 32'h0;
    assign hwrite_o      = (state_q == S_RUN) & store_q;
    assign hsize_o       = 3'b010;
    assign hwdata_o      = wdata_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign vrf_rd_elem_o = row_a;
    assign vrf_wr_elem_o = wr_row_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign vrf_wr_en_o[l] = wr_en_q[l];
        assign vrf_wdata_o[l] = rowbuf_q[l];
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            store_q   <= 1'b0;
            vm_q      <= 1'b0;
            indexed_q <= 1'b0;
            err_q     <= 1'b0;
            dp_vld_q  <= 1'b0;
            dp_act_q  <= 1'b0;
            mask_q    <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            dp_idx_q  <= '0;
            wr_row_q  <= '0;
            wr_en_q   <= '0;
            for (int l = 0; l < LANES; l++) rowbuf_q[l] <= '0;
        end else begin
            wr_en_q <= '0;
            // Masked slots still close their row so the writeback fires on schedule.
            if (dp_done && !store_q) begin
                if (dp_act_q) rowbuf_q[dp_lane] <= hrdata_i;
                if (dp_lane == LANE_B'(LANES-1)) begin
                    wr_en_q  <= wb_en;
                    wr_row_q <= dp_row;
                end
            end
            case (state_q)
                S_IDLE: if (req_i && op_ok) begin
                    state_q  <= S_RUN;
                    store_q  <= (instr_i[6:0] == OP_STORE);
                    vm_q     <= instr_i[25];
                    mask_q   <= mask_i;
                    base_q   <= rs1_i;
                    acc_q    <= rs1_i;
                    step_q   <= (instr_i[27:26] == 2'b10) ? rs2_i : 32'd4;
`ifdef VLSU_INDEXED_EN
                    indexed_q <= instr_i[26];
`else
                    indexed_q <= 1'b0;
`endif
                    idx_q    <= '0;
                    err_q    <= 1'b0;
                    dp_vld_q <= 1'b0;
                end
                S_RUN: if (err_now) begin
                    state_q  <= S_DONE;
                    err_q    <= 1'b1;
                    dp_vld_q <= 1'b0;
                end else if (hready_i) begin
                    dp_vld_q <= 1'b1;
                    dp_act_q <= elem_act;
                    dp_idx_q <= idx_q;
                    if (store_q && elem_act) wdata_q <= vs3_rdata_i[lane_a];
                    idx_q    <= idx_q + 1'b1;
                    acc_q    <= acc_q + step_q;
                    if (idx_q == IDX_W'(N-1)) state_q <= S_DRAIN;
                end
                S_DRAIN: if (err_now || hready_i) begin
                    state_q  <= S_DONE;
                    err_q    <= err_q | err_now;
                    dp_vld_q <= 1'b0;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vlsu_pipe.sv
// Bench for vlsu_pipe: directed and random instructions checked against a transaction-level
// model of bus transfers, row writebacks and completion timing.
`timescale 1ns/1ps
module tb_vlsu_pipe;
    localparam int         LANES  = 4;
    localparam int         ELEMS  = 4;
    localparam int         ELEM_B = $clog2(ELEMS);
    localparam int         N      = LANES*ELEMS;
    localparam logic [6:0] OP_LD  = 7'b0000111;
    localparam logic [6:0] OP_ST  = 7'b0100111;

    logic              clk_i = 1'b0;
    logic              resetn_i, req_i;
    logic [31:0]       instr_i, rs1_i, rs2_i;
    logic [31:0]       vs2_rdata_i [LANES];
    logic [31:0]       vs3_rdata_i [LANES];
    logic [N-1:0]      mask_i;
    logic [ELEM_B-1:0] vrf_rd_elem_o, vrf_wr_elem_o;
    logic              vrf_wr_en_o [LANES];
    logic [31:0]       vrf_wdata_o [LANES];
    logic              busy_o, done_o, err_o;
    logic [31:0]       haddr_o, hwdata_o, hrdata_i;
    logic [1:0]        htrans_o;
    logic              hwrite_o, hready_i, hresp_i;
    logic [2:0]        hsize_o;

    logic [31:0] vs2_mem [ELEMS][LANES];
    logic [31:0] vs3_mem [ELEMS][LANES];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    for (genvar l = 0; l < LANES; l++) begin : g_vrf
        assign vs2_rdata_i[l] = vs2_mem[vrf_rd_elem_o][l];
        assign vs3_rdata_i[l] = vs3_mem[vrf_rd_elem_o][l];
    end

    vlsu_pipe #(.LANES(LANES), .ELEMS(ELEMS)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .instr_i(instr_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .vs2_rdata_i(vs2_rdata_i), .vs3_rdata_i(vs3_rdata_i),
        .mask_i(mask_i), .vrf_rd_elem_o(vrf_rd_elem_o), .vrf_wr_elem_o(vrf_wr_elem_o),
        .vrf_wr_en_o(vrf_wr_en_o), .vrf_wdata_o(vrf_wdata_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .haddr_o(haddr_o), .htrans_o(htrans_o),
        .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hwdata_o(hwdata_o), .hrdata_i(hrdata_i),
        .hready_i(hready_i), .hresp_i(hresp_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'h5A3C_0000;
    endfunction

    function automatic logic [LANES-1:0] wr_en_bits();
        logic [LANES-1:0] v;
        for (int l = 0; l < LANES; l++) v[l] = vrf_wr_en_o[l];
        return v;
    endfunction

    task automatic fill_vrf();
        for (int r = 0; r < ELEMS; r++)
            for (int l = 0; l < LANES; l++) begin
                vs2_mem[r][l] = $urandom;
                vs3_mem[r][l] = $urandom;
            end
    endtask

    // err_k: index of the bus transfer answered with hresp (-1 none); exp_done: done cycle (-1 skip).
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [N-1:0] mask, input bit rnd_stall, input int stall_c,
                             input int err_k, input int exp_done);
        logic [31:0] exp_addr[$];
        int          exp_elem[$];
        logic [31:0] obs_addr[$];
        logic        obs_wr[$];
        logic [31:0] wb_row[$];
        logic [LANES-1:0] wb_en[$];
        logic [31:0] wb_dat[$];
        logic [31:0] ea [N];
        logic [1:0]  mop;
        logic [1:0]  p_trans;
        logic [31:0] p_addr, p_wdata, dp_addr;
        logic [LANES-1:0] en_now;
        bit is_st, vm, dp_vld, p_busy, p_rdy;
        int dp_seq, done_cnt, done_c, err_c, k_max, n_wb;

        is_st = (instr[6:0] == OP_ST);
        vm = instr[25];
        mop = instr[27:26];
        for (int i = 0; i < N; i++) begin
            if (mop == 2'b10) ea[i] = rs1 + 32'(i) * rs2;
`ifdef VLSU_INDEXED_EN
            else if (mop[0]) ea[i] = rs1 + vs2_mem[i / LANES][i % LANES];
`endif
            else ea[i] = rs1 + 32'(4 * i);
            if (vm || mask[i]) begin
                exp_addr.push_back(ea[i]);
                exp_elem.push_back(i);
            end
        end

        dp_vld = 0; dp_addr = 0; dp_seq = 0; p_busy = 0; p_rdy = 1;
        p_trans = 0; p_addr = 0; p_wdata = 0;
        done_cnt = 0; done_c = -1; err_c = -1;

        @(posedge clk_i); #1;
        req_i = 1; instr_i = instr; rs1_i = rs1; rs2_i = rs2; mask_i = mask;
        hready_i = 1; hresp_i = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk_i); #1;
            req_i = 0;
            hready_i = 1'b1;
            if (rnd_stall && $urandom_range(0, 3) == 0) hready_i = 1'b0;
            if (c == stall_c || c == stall_c + 1) hready_i = 1'b0;
            hresp_i = dp_vld && (dp_seq == err_k);
            if (hresp_i) begin
                hready_i = 1'b1;
                err_c = c;
            end
            hrdata_i = dp_vld ? rd_val(dp_addr) : 32'h0;
            @(negedge clk_i);
            if (c == 1) begin
                check("busy_c1", busy_o, 1);
                check("err_clr", err_o, 0);
            end
            if (p_busy && busy_o && !p_rdy && !hresp_i) begin
                check("hold_haddr", haddr_o, p_addr);
                check("hold_htrans", htrans_o, p_trans);
                check("hold_hwdata", hwdata_o, p_wdata);
            end
            if (done_o) begin
                done_cnt++;
                done_c = c;
            end
            en_now = wr_en_bits();
            if (en_now != 0) begin
                wb_row.push_back(32'(vrf_wr_elem_o));
                wb_en.push_back(en_now);
                for (int l = 0; l < LANES; l++) wb_dat.push_back(vrf_wdata_o[l]);
            end
            if (dp_vld && hready_i && !hresp_i && is_st && dp_seq < exp_elem.size())
                check("hwdata", hwdata_o,
                      vs3_mem[exp_elem[dp_seq] / LANES][exp_elem[dp_seq] % LANES]);
            if (hresp_i) begin
                check("cancel_htrans", htrans_o, 0);
                dp_vld = 0;
            end else if (hready_i) begin
                if (htrans_o == 2'b10) begin
                    obs_addr.push_back(haddr_o);
                    obs_wr.push_back(hwrite_o);
                    dp_vld = 1;
                    dp_addr = haddr_o;
                    dp_seq = obs_addr.size() - 1;
                end else dp_vld = 0;
            end
            p_busy = busy_o; p_rdy = hready_i; p_trans = htrans_o;
            p_addr = haddr_o; p_wdata = hwdata_o;
            if (done_c >= 0 && c >= done_c + 2) break;
        end
        hready_i = 1; hresp_i = 0;

        k_max = (err_k >= 0) ? err_k + 1 : exp_addr.size();
        check("n_xfer", obs_addr.size(), k_max);
        for (int k = 0; k < k_max && k < obs_addr.size(); k++) begin
            check("haddr", obs_addr[k], exp_addr[k]);
            check("hwrite", obs_wr[k], is_st);
        end
        check("done_cnt", done_cnt, 1);
        if (err_k >= 0) check("done_after_err", done_c, err_c + 1);
        else if (exp_done >= 0) check("done_cyc", done_c, exp_done);
        check("err_o", err_o, (err_k >= 0));
        check("busy_end", busy_o, 0);

        n_wb = 0;
        if (!is_st) begin
            for (int r = 0; r < ELEMS; r++) begin
                logic [LANES-1:0] en_r;
                int last;
                for (int l = 0; l < LANES; l++) en_r[l] = vm || mask[r * LANES + l];
                last = r * LANES + LANES - 1;
                if (en_r != 0 && (err_k < 0 || last < exp_elem[err_k])) begin
                    if (n_wb < wb_row.size()) begin
                        check("wb_row", wb_row[n_wb], r);
                        check("wb_en", 32'(wb_en[n_wb]), 32'(en_r));
                        for (int l = 0; l < LANES; l++)
                            if (en_r[l]) check("wb_data", wb_dat[n_wb * LANES + l],
                                               rd_val(ea[r * LANES + l]));
                    end
                    n_wb++;
                end
            end
        end
        check("n_wb", wb_row.size(), n_wb);
    endtask

    initial begin
        logic [1:0] mop;
        logic [N-1:0] msk;
        bit st, vm, stl;
        int na, ek, dc, bc, wc;

        resetn_i = 0; req_i = 0; instr_i = 0; rs1_i = 0; rs2_i = 0; mask_i = 0;
        hrdata_i = 0; hready_i = 1; hresp_i = 0;
        fill_vrf();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_htrans", htrans_o, 0);
        check("rst_hsize", hsize_o, 3'b010);
        check("rst_haddr", haddr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_hwrite", hwrite_o, 0);
        check("rst_wren", 32'(wr_en_bits()), 0);
        @(posedge clk_i); #1 resetn_i = 1;

        run_instr({4'h0, 2'b00, 1'b1, 18'h0, OP_LD}, 32'h1000, 32'h0, '1, 0, -10, -1, N + 2);
        fill_vrf();
        run_instr({4'h0, 2'b10, 1'b1, 18'h0, OP_ST}, 32'h2000, 32'h10, '1, 0, 6, -1, N + 4);
        run_instr({4'h0, 2'b00, 1'b0, 18'h0, OP_LD}, 32'h1000, 32'h0, N'(16'hAAAA), 0, -10, -1, N + 2);
        run_instr({4'h0, 2'b00, 1'b1, 18'h0, OP_LD}, 32'h1000, 32'h0, '1, 0, -10, 6, -1);
        fill_vrf();
        vs2_mem[0][0] = 32'h0;   vs2_mem[0][1] = 32'h40;
        vs2_mem[0][2] = 32'h8;   vs2_mem[0][3] = 32'h100;
        run_instr({4'h0, 2'b01, 1'b1, 18'h0, OP_LD}, 32'h3000, 32'h0, '1, 0, -10, -1, N + 2);
        run_instr({4'h0, 2'b00, 1'b0, 18'h0, OP_LD}, 32'h1000, 32'h0, '0, 0, -10, -1, N + 2);

        // Invalid opcode is dropped.
        @(posedge clk_i); #1 req_i = 1; instr_i = 32'h0000_0033;
        @(posedge clk_i); #1 req_i = 0;
        dc = 0; bc = 0;
        repeat (5) begin
            @(negedge clk_i);
            dc += int'(done_o);
            bc += int'(busy_o);
        end
        check("inv_busy", bc, 0);
        check("inv_done", dc, 0);

        for (int t = 0; t < 30; t++) begin
            mop = 2'($urandom);
            st = 1'($urandom);
            vm = ($urandom_range(0, 2) == 0);
            msk = N'($urandom);
            stl = 1'($urandom);
            na = vm ? N : $countones(msk);
            ek = (na > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, na - 1)) : -1;
            fill_vrf();
            run_instr({4'($urandom), mop, vm, 18'($urandom), st ? OP_ST : OP_LD},
                      $urandom, $urandom, msk, stl, -10, ek, (!stl && ek < 0) ? N + 2 : -1);
        end

        // Second request while busy is ignored, then reset aborts mid-run.
        @(posedge clk_i); #1;
        req_i = 1; instr_i = {4'h0, 2'b00, 1'b1, 18'h0, OP_LD}; rs1_i = 32'h4000; mask_i = '1;
        hready_i = 1; hresp_i = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk_i); #1;
            req_i = 1; instr_i = {4'h0, 2'b00, 1'b1, 18'h0, OP_ST}; rs1_i = 32'h8000;
            @(negedge clk_i);
            check("busy_req_addr", haddr_o, 32'h4000 + 32'(4 * (c - 1)));
            check("busy_req_wr", hwrite_o, 0);
        end
        #1 resetn_i = 0; req_i = 0;
        #1;
        check("abort_htrans", htrans_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_wren", 32'(wr_en_bits()), 0);
        repeat (2) @(posedge clk_i);
        #1 resetn_i = 1;
        dc = 0; bc = 0; wc = 0;
        repeat (20) begin
            @(negedge clk_i);
            dc += int'(done_o);
            bc += int'(busy_o);
            wc += int'(wr_en_bits() != 0);
        end
        check("post_rst_done", dc, 0);
        check("post_rst_busy", bc, 0);
        check("post_rst_wb", wc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vlsu_pipe.md
# vlsu_pipe

Pipelined, parametrised vector load/store unit. It executes one RVV-style vector load or store at a time, covering `LANES*ELEMS` 32-bit elements. The address phase of one element overlaps the data phase of the previous one on an AHB-Lite master port. It sits between the vector issue stage and the vector register file (VRF), and adds three things: per-element masking without bus traffic, AHB error abort, and an optional indexed addressing mode.

## Interface
- `LANES`, 4, number of VRF lanes (power of two, ≥2).
- `ELEMS`, 4, element rows per vector register (power of two, ≥2).
- `ELEM_B`, `$clog2(ELEMS)`, row-index width (localparam).
- `N`, `LANES*ELEMS`, elements per instruction (localparam).

Ports:
- `clk_i` in 1: clock.
- `resetn_i` in 1: reset, asynchronous, active-low.
- `req_i` in 1: instruction request, sampled only in IDLE.
- `instr_i` in 32: instruction.
  - `[6:0]`: 0000111 = load, 0100111 = store; any other value is ignored.
  - `[25]`: vm (1 = unmasked).
  - `[27:26]`: mop (00 unit, 10 strided, 01/11 indexed).
- `rs1_i` in 32: base address.
- `rs2_i` in 32: byte stride.
- `vs2_rdata_i[LANES]` in 32 each: index operands of row `vrf_rd_elem_o`.
- `vs3_rdata_i[LANES]` in 32 each: store data of row `vrf_rd_elem_o`.
- `mask_i` in N: mask bits; bit i belongs to element i.
- `vrf_rd_elem_o` out ELEM_B: VRF read row.
- `vrf_wr_elem_o` out ELEM_B: VRF write row.
- `vrf_wr_en_o[LANES]` out 1 each: per-lane write enables.
- `vrf_wdata_o[LANES]` out 32 each: load writeback data.
- `busy_o` out 1: instruction in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky bus error flag.
- `haddr_o` out 32, `htrans_o` out 2, `hwrite_o` out 1, `hsize_o` out 3, `hwdata_o` out 32: AHB master outputs.
- `hrdata_i` in 32, `hready_i` in 1, `hresp_i` in 1: AHB slave responses.

## Operation
**Element numbering.** Element i = row\*LANES + lane, with i from 0 to N-1. Elements are issued in ascending i.

**Addressing.** Arithmetic is 32-bit and wraps modulo 2^32.
- Unit: rs1 + 4\*i.
- Strided: rs1 + i\*rs2.
- Indexed: rs1 + vs2_rdata_i[lane].

**Latched operands.** On acceptance, the unit latches instr_i, rs1_i, rs2_i and mask_i. The source VRF operands must stay stable for the current `vrf_rd_elem_o`.

**Masking.** An element is masked off when vm=0 and its mask bit is 0. A masked element consumes one address slot, drives `htrans_o`=IDLE, produces no bus transfer, and has its `vrf_wr_en_o` held low.

**Row writeback (loads).** hrdata is captured per lane into a row buffer. When the data phase of the last lane of a row completes (or that lane is masked), the next cycle does the following for exactly one cycle:
- drives `vrf_wr_elem_o` = row;
- drives `vrf_wdata_o` from the buffer;
- asserts `vrf_wr_en_o[lane]` for every unmasked lane of that row.

**Store data.** `vs3_rdata_i[lane]` is registered when the address phase is accepted, and driven on `hwdata_o` during the matching data phase.

**FSM.**
- IDLE → RUN when req_i=1 with a valid opcode. A request with an invalid opcode is dropped and causes no done_o.
- RUN issues one element per accepted address phase. After element N-1 is issued → DRAIN.
- DRAIN waits for the last data phase to complete (`hready_i`=1) → DONE.
- DONE pulses done_o, performs the final load row writeback if one is pending, then → IDLE.
- req_i is ignored outside IDLE.

**Bus error.** `hresp_i`=1 in a data phase does the following:
- htrans is forced to IDLE in that cycle, cancelling the pipelined address;
- err_o is set;
- done_o pulses the next cycle and the FSM returns to IDLE;
- the partial row writeback is suppressed (writebacks already issued stand).

err_o clears on the next accepted request.

**hsize.** `hsize_o` is fixed at 3'b010 (word).

## Timing
**Reset values.** While reset is asserted, all outputs are 0 except the following:
- `htrans_o`=2'b00 (IDLE);
- `hsize_o`=3'b010;
- `haddr_o`=0.

Reset mid-operation aborts immediately, with no done_o and no writeback.

**Issue timing.**
- req accepted at cycle 0.
- First address phase (NONSEQ) at cycle 1; `busy_o`=1 from cycle 1 through the DONE cycle.
- With zero wait states, throughput is one element per cycle.
- Unit-stride, unmasked, no-wait-state instruction: the last data phase is in cycle N+1, DONE in cycle N+2.

**hready_i=0.** All address and data phase signals are held and the counters are frozen.

**All elements masked.** The unit runs N idle slots, DONE at cycle N+2, with zero bus transfers.

**`vrf_rd_elem_o`** equals the row of the element currently in address phase.

## Configuration
- `VLSU_INDEXED_EN` defined: mop 01/11 use indexed addressing from `vs2_rdata_i`.
- `VLSU_INDEXED_EN` undefined: mop 01/11 behave as unit stride, and `vs2_rdata_i` is unused.

## Test plan
- Unit-stride load, LANES=4, ELEMS=4, rs1=0x1000, zero wait states, hrdata=addr → addresses 0x1000..0x103C in consecutive cycles; 4 row writebacks with all enables=1111; done_o at cycle 18.
- Strided store, rs2=0x10, rs1=0x2000, hready low for 2 cycles on element 5 → hwrite=1; addresses 0x2000+0x10\*i; hwdata=vs3 of the matching element; all signals held during the stall.
- Masked load, vm=0, mask=0xAAAA → only odd elements produce NONSEQ; vrf_wr_en_o=1010 on every row.
- hresp=1 on element 6 of a load → the pipelined element-7 address is cancelled; err_o=1; done_o next cycle; rows 0 (elements 0-3) written, row 1 not written.
- Indexed load, vs2={0x0,0x40,0x8,0x100}, rs1=0x3000 (VLSU_INDEXED_EN defined) → row-0 addresses 0x3000, 0x3040, 0x3008, 0x3100; with the macro undefined → 0x3000..0x300C.
- req_i while busy, then assert resetn_i low mid-RUN → the second request is ignored; after reset htrans=IDLE, busy_o=0, no done_o.
